seq_pattern_tx: RTL and testbench

- Serial bit-pattern transmitter: the generating end of the serial bit stream that the team's sequence detectors consume.
- Accepts a parallel pattern word, length and repeat count over a valid/ready handshake.
- Shifts the pattern out MSB-first, one bit per clock, with a qualifying strobe.
- Drives detector benches and on-chip serial stimulus paths.

---
 rtl/seq_pattern_tx.sv | 145 ++++++++++++++
 tb/tb_seq_pattern_tx.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_pattern_tx.sv
// Serial bit-pattern transmitter: shifts a latched pattern out MSB-first with
// repeats and optional inter-repeat gaps. SEQ_PATTERN_TX_EXPZ_EN adds exp_z (1010 reference).
module seq_pattern_tx #(
  parameter int W     = 8,
  parameter int RPT_W = 4,
  parameter int GAP   = 0,
  localparam int LW   = $clog2(W + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_pat,
  input  logic [LW-1:0]    in_len,
  input  logic [RPT_W-1:0] in_rpt,
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic             done
`ifdef SEQ_PATTERN_TX_EXPZ_EN
  ,
  output logic             exp_z
`endif
);

  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_GAP} state_t;

  state_t           r_state, w_nxt_state;
  logic [W-1:0]     r_pat;
  logic [LW-1:0]    r_len, r_idx, w_nxt_idx, w_len_c;
  logic [RPT_W-1:0] r_rpt, w_nxt_rpt;
  logic [GW-1:0]    r_gap, w_nxt_gap;
  logic             r_zdone;
  logic             w_accept;
  logic [W-1:0]     w_shifted;

  // A zero-length request still owns the pulse cycle, so in_ready drops there too.
  assign in_ready  = (r_state == ST_IDLE) && !r_zdone && !rst;
  assign w_accept  = in_valid && in_ready;
  assign w_len_c   = (in_len > LW'(W)) ? LW'(W) : in_len;
  assign busy      = (r_state != ST_IDLE);
  assign w_shifted = r_pat >> r_idx;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    w_nxt_state = r_state;
    w_nxt_idx   = r_idx;
    w_nxt_rpt   = r_rpt;
    w_nxt_gap   = r_gap;
    x           = 1'b0;
    x_valid     = 1'b0;
    done        = r_zdone;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && (w_len_c != '0)) begin
          w_nxt_state = ST_SHIFT;
          w_nxt_idx   = w_len_c - LW'(1);
          w_nxt_rpt   = in_rpt;
        end
      end
      ST_SHIFT: begin
        x       = w_shifted[0];
        x_valid = 1'b1;
        if (r_idx == '0) begin
          if (r_rpt == '0) begin
            done        = 1'b1;
            w_nxt_state = ST_IDLE;
          end else begin
            w_nxt_rpt = r_rpt - RPT_W'(1);
            if (GAP == 0) begin
              w_nxt_idx = r_len - LW'(1);
            end else begin
              w_nxt_state = ST_GAP;
              w_nxt_gap   = GW'(GAP - 1);
            end
          end
        end else begin
          w_nxt_idx = r_idx - LW'(1);
        end
      end
      ST_GAP: begin
        if (r_gap == '0) begin
          w_nxt_state = ST_SHIFT;
          w_nxt_idx   = r_len - LW'(1);
        end else begin
          w_nxt_gap = r_gap - GW'(1);
        end
      end
      default: w_nxt_state = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_pat   <= '0;
      r_len   <= '0;
      r_idx   <= '0;
      r_rpt   <= '0;
      r_gap   <= '0;
      r_zdone <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_idx   <= w_nxt_idx;
      r_rpt   <= w_nxt_rpt;
      r_gap   <= w_nxt_gap;
      r_zdone <= w_accept && (w_len_c == '0);
      if (w_accept) begin
        r_pat <= in_pat;
        r_len <= w_len_c;
      end
    end
  end

`ifdef SEQ_PATTERN_TX_EXPZ_EN
  typedef enum logic [1:0] {D_S0, D_S1, D_S2, D_S3} det_t;

  det_t r_det, w_det_nxt;

  // Overlapping Mealy 1010 reference; only qualified bits advance it.
  always_comb begin
    w_det_nxt = r_det;
    if (x_valid) begin
      case (r_det)
        D_S0:    w_det_nxt = x ? D_S1 : D_S0;
        D_S1:    w_det_nxt = x ? D_S1 : D_S2;
        D_S2:    w_det_nxt = x ? D_S3 : D_S0;
        D_S3:    w_det_nxt = x ? D_S1 : D_S2;
        default: w_det_nxt = D_S0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_det <= D_S0;
    else     r_det <= w_det_nxt;
  end

  assign exp_z = x_valid && (r_det == D_S3) && !x;
`endif

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Randomized self-checking bench for seq_pattern_tx against a stream-level reference model.
module tb_seq_pattern_tx;

  localparam int W     = 8;
  localparam int RPT_W = 4;
  localparam int LW    = $clog2(W + 1);
`ifdef SEQ_PATTERN_TX_EXPZ_EN
  localparam int TGAP  = 0;
`else
  localparam int TGAP  = 2;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [W-1:0]     in_pat = '0;
  logic [LW-1:0]    in_len = '0;
  logic [RPT_W-1:0] in_rpt = '0;
  logic             x, x_valid, busy, done;
`ifdef SEQ_PATTERN_TX_EXPZ_EN
  logic             exp_z;
`endif

  seq_pattern_tx #(.W(W), .RPT_W(RPT_W), .GAP(TGAP)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_pat(in_pat), .in_len(in_len), .in_rpt(in_rpt),
    .x(x), .x_valid(x_valid), .busy(busy), .done(done)
`ifdef SEQ_PATTERN_TX_EXPZ_EN
    , .exp_z(exp_z)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {bit x; bit xv; bit dn;} ev_t;

  int n_vec = 0;
  int n_err = 0;
  // Reference history of qualified bits for the 1010 check.
  bit [2:0] hist = '0;
  int       nval = 0;
  bit [W-1:0] ez_mask;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_transfer(input logic [W-1:0] pat, input int len, input int rpt);
    ev_t q[$];
    int  l;
    int  waits = 0;
    int  vbit = 0;
    bit  ez;
    logic [4:0] obs, expv;
    l = (len > W) ? W : len;
    if (l == 0) q.push_back('{1'b0, 1'b0, 1'b1});
    else
      for (int r = 0; r <= rpt; r++) begin
        for (int i = l - 1; i >= 0; i--) q.push_back('{pat[i], 1'b1, (r == rpt) && (i == 0)});
        if (r < rpt) for (int g = 0; g < TGAP; g++) q.push_back('{1'b0, 1'b0, 1'b0});
      end
    while (!in_ready && waits < 50) begin step(); waits++; end
    if (!in_ready) begin
      n_vec++; n_err++;
      $display("FAIL ready_timeout: in_ready=%b after %0d cycles, required 1", in_ready, waits);
    end
    in_pat = pat; in_len = LW'(len); in_rpt = RPT_W'(rpt); in_valid = 1'b1;
    step();
    ez_mask = '0;
    foreach (q[k]) begin
      obs  = {x, x_valid, done, busy, in_ready};
      expv = {q[k].x, q[k].xv, q[k].dn, (l != 0), 1'b0};
      n_vec++;
      if (obs !== expv) begin
        n_err++;
        $display("FAIL stream[%0d] pat=%h len=%0d rpt=%0d: {x,xv,done,busy,rdy}=%b required %b",
                 k, pat, len, rpt, obs, expv);
      end
`ifdef SEQ_PATTERN_TX_EXPZ_EN
      ez = q[k].xv && (nval >= 3) && (hist == 3'b101) && !q[k].x;
      if (q[k].xv) begin
        hist = {hist[1:0], q[k].x};
        nval++;
        if (exp_z === 1'b1 && vbit < W) ez_mask[vbit] = 1'b1;
        vbit++;
      end
      n_vec++;
      if (exp_z !== ez) begin
        n_err++;
        $display("FAIL exp_z[%0d]: got %b required %b", k, exp_z, ez);
      end
`endif
      // Garbage on the request inputs while busy must be ignored.
      in_valid = 1'($urandom);
      in_pat   = W'($urandom);
      in_len   = LW'($urandom);
      in_rpt   = RPT_W'($urandom);
      step();
    end
    in_valid = 1'b0;
    #1;
    obs = {x, x_valid, done, busy, in_ready};
    n_vec++;
    if (obs !== 5'b00001) begin
      n_err++;
      $display("FAIL post_idle pat=%h len=%0d: {x,xv,done,busy,rdy}=%b required 00001", pat, len, obs);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0;
    step();
    n_vec++;
    if ({x, x_valid, done, busy, in_ready} !== 5'b00000) begin
      n_err++;
      $display("FAIL reset_state: {x,xv,done,busy,rdy}=%b required 00000",
               {x, x_valid, done, busy, in_ready});
    end
    step();
    rst = 1'b0; hist = '0; nval = 0;
    #1;
    n_vec++;
    if ({in_ready, busy, x_valid} !== 3'b100) begin
      n_err++;
      $display("FAIL post_reset: {rdy,busy,xv}=%b required 100", {in_ready, busy, x_valid});
    end
  endtask

  task automatic test_single();
    do_transfer(8'b0000_1010, 4, 0);
  endtask

  task automatic test_repeat();
    do_transfer(8'b0000_0110, 3, 2);
  endtask

  task automatic test_clamp_zero();
    do_transfer(8'hB7, 12, 0);
    do_transfer(8'hFF, 0, 3);
    do_transfer(8'h81, 8, 1);
  endtask

  task automatic test_abort();
    logic [W-1:0] pat = 8'hA5;
    int waits = 0;
    while (!in_ready && waits < 50) begin step(); waits++; end
    in_pat = pat; in_len = LW'(8); in_rpt = RPT_W'(1); in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    n_vec++;
    if ({x, x_valid} !== {pat[5], 1'b1}) begin
      n_err++;
      $display("FAIL abort_bit3: {x,xv}=%b required %b", {x, x_valid}, {pat[5], 1'b1});
    end
    rst = 1'b1;
    step();
    n_vec++;
    if ({x_valid, done, busy, in_ready} !== 4'b0000) begin
      n_err++;
      $display("FAIL abort_idle: {xv,done,busy,rdy}=%b required 0000", {x_valid, done, busy, in_ready});
    end
    rst = 1'b0; hist = '0; nval = 0;
    #1;
    n_vec++;
    if ({done, in_ready} !== 2'b01) begin
      n_err++;
      $display("FAIL abort_recover: {done,rdy}=%b required 01", {done, in_ready});
    end
    do_transfer(8'h3C, 8, 0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      int idle = $urandom_range(0, 2);
      for (int i = 0; i < idle; i++) step();
      do_transfer(W'($urandom), $urandom_range(0, W + 3), $urandom_range(0, 3));
    end
  endtask

`ifdef SEQ_PATTERN_TX_EXPZ_EN
  task automatic test_expz();
    test_reset();
    do_transfer(8'b0101_0100, 7, 0);
    n_vec++;
    if (ez_mask !== 8'b0010_1000) begin
      n_err++;
      $display("FAIL expz_positions: mask=%b required 00101000", ez_mask);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_repeat();
    test_clamp_zero();
    test_abort();
    test_random();
`ifdef SEQ_PATTERN_TX_EXPZ_EN
    test_expz();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
